// File: rtl/board_turn_controller.sv
`timescale 1ns / 1ps
// board_turn_controller
//
// Turn sequencer for a 5x5 board game. Owns the board cell storage, the cursor
// and whose turn it is. Every legal placement is followed by a fixed-length win
// scan along four axes through the placed cell, and the outcome is reported to
// the match scorer. The display reads cells through a registered read port.
//
// Optional feature: define MOVE_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES idle cycles. Without it, IDLE waits indefinitely.
//
// Parameters:
//   WIN_LEN         run length that wins (3..5)
//   TIMEOUT_CYCLES  idle cycles before a turn is forfeited (MOVE_TIMEOUT_EN only)
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   btn_l/btn_r/btn_u/btn_d      single-cycle cursor-move pulses
//   place                        place current player's marker at the cursor
//   reset_game                   clear board, start a new game
//   rd_row, rd_col -> rd_cell    registered display read (00 empty, 01 P1, 10 P2)
//   cursor_row, cursor_col       cursor position 0..4
//   player1_turn, player2_turn   one-hot turn LEDs, both 0 when the game is over
//   game_finished                one-cycle pulse on game end
//   last_winner                  0 = P1, 1 = P2
//   draw                         last game ended on a full board with no winner
//   invalid_move                 one-cycle pulse when place hits an occupied cell
//   busy                         high during the win scan
module board_turn_controller #(
  parameter int unsigned WIN_LEN        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       place,
  input  logic       reset_game,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell,
  output logic [2:0] cursor_row,
  output logic [2:0] cursor_col,
  output logic       player1_turn,
  output logic       player2_turn,
  output logic       game_finished,
  output logic       last_winner,
  output logic       draw,
  output logic       invalid_move,
  output logic       busy
);

  if (WIN_LEN < 3 || WIN_LEN > 5 || TIMEOUT_CYCLES == 0) begin : gen_bad_params
    $error("board_turn_controller: WIN_LEN must be 3..5 and TIMEOUT_CYCLES nonzero");
  end

  localparam int unsigned Span    = 2 * WIN_LEN - 1;
  localparam logic [3:0]  OffLast = 4'(Span - 1);
  localparam logic [2:0]  WinLen3 = 3'(WIN_LEN);

  typedef enum logic [1:0] {StIdle, StCheck, StResolve, StDone} state_e;

  state_e     state_q;
  logic [1:0] board_q [25];
  logic [2:0] cur_row_q, cur_col_q;
  logic [2:0] prow_q, pcol_q;
  logic [4:0] move_cnt_q;
  logic       cur_p2_q;
  logic       starter_p2_q;
  logic [1:0] axis_q;
  logic [3:0] off_q;
  logic [2:0] run_q;
  logic       win_q;
  logic       game_finished_q, last_winner_q, draw_q, invalid_move_q;
  logic [1:0] rd_cell_q;

`ifdef MOVE_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] idle_cnt_q;
`else
  // No idle timer: IDLE waits indefinitely for input.
`endif

  logic [1:0] player_code;
  logic [4:0] cur_idx;
  logic       cur_empty;
  logic [4:0] rd_idx;
  logic       rd_in_range;
  logic [1:0] rd_data;

  assign player_code = cur_p2_q ? 2'b10 : 2'b01;
  assign cur_idx     = {2'b00, cur_row_q} * 5'd5 + {2'b00, cur_col_q};
  assign cur_empty   = (board_q[cur_idx] == 2'b00);
  assign rd_in_range = (rd_row < 3'd5) && (rd_col < 3'd5);
  assign rd_idx      = {2'b00, rd_row} * 5'd5 + {2'b00, rd_col};
  assign rd_data     = rd_in_range ? board_q[rd_idx] : 2'b00;

  // Win-scan datapath: one cell per cycle at offset k along the current axis.
  int         k_s, dr_s, dc_s, tr_s, tc_s;
  logic       in_bounds;
  logic [4:0] tgt_idx;
  logic [1:0] tgt_cell;
  logic       match;
  logic [2:0] run_base, run_next;
  logic       hit;

  always_comb begin
    k_s = int'(off_q) - (int'(WIN_LEN) - 1);
    case (axis_q)
      2'd0:    begin dr_s = 0; dc_s = 1;  end
      2'd1:    begin dr_s = 1; dc_s = 0;  end
      2'd2:    begin dr_s = 1; dc_s = 1;  end
      default: begin dr_s = 1; dc_s = -1; end
    endcase
    tr_s      = int'(prow_q) + dr_s * k_s;
    tc_s      = int'(pcol_q) + dc_s * k_s;
    in_bounds = (tr_s >= 0) && (tr_s <= 4) && (tc_s >= 0) && (tc_s <= 4);
    tgt_idx   = in_bounds ? 5'(tr_s * 5 + tc_s) : 5'd0;
    tgt_cell  = board_q[tgt_idx];
    match     = in_bounds && ((k_s == 0) || (tgt_cell == player_code));
    // Run restarts at the first offset of every axis.
    run_base  = (off_q == 4'd0) ? 3'd0 : run_q;
    run_next  = match ? run_base + 3'd1 : 3'd0;
    hit       = (run_next >= WinLen3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      for (int i = 0; i < 25; i++) board_q[i] <= 2'b00;
      cur_row_q       <= 3'd2;
      cur_col_q       <= 3'd2;
      prow_q          <= 3'd0;
      pcol_q          <= 3'd0;
      move_cnt_q      <= 5'd0;
      cur_p2_q        <= 1'b0;
      starter_p2_q    <= 1'b0;
      axis_q          <= 2'd0;
      off_q           <= 4'd0;
      run_q           <= 3'd0;
      win_q           <= 1'b0;
      game_finished_q <= 1'b0;
      last_winner_q   <= 1'b0;
      draw_q          <= 1'b0;
      invalid_move_q  <= 1'b0;
      rd_cell_q       <= 2'b00;
`ifdef MOVE_TIMEOUT_EN
      idle_cnt_q      <= 32'd0;
`endif
    end else begin
      game_finished_q <= 1'b0;
      invalid_move_q  <= 1'b0;
      rd_cell_q       <= rd_data;

      if (reset_game) begin
        // New game: the player who did not start the previous game goes first.
        state_q      <= StIdle;
        for (int i = 0; i < 25; i++) board_q[i] <= 2'b00;
        cur_row_q    <= 3'd2;
        cur_col_q    <= 3'd2;
        move_cnt_q   <= 5'd0;
        starter_p2_q <= ~starter_p2_q;
        cur_p2_q     <= ~starter_p2_q;
        axis_q       <= 2'd0;
        off_q        <= 4'd0;
        run_q        <= 3'd0;
        win_q        <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
        idle_cnt_q   <= 32'd0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            if (place) begin
              if (cur_empty) begin
                board_q[cur_idx] <= player_code;
                prow_q           <= cur_row_q;
                pcol_q           <= cur_col_q;
                move_cnt_q       <= move_cnt_q + 5'd1;
                axis_q           <= 2'd0;
                off_q            <= 4'd0;
                run_q            <= 3'd0;
                win_q            <= 1'b0;
                state_q          <= StCheck;
              end else begin
                invalid_move_q <= 1'b1;
              end
            end else if (btn_u) begin
              cur_row_q <= (cur_row_q == 3'd0) ? 3'd4 : cur_row_q - 3'd1;
            end else if (btn_d) begin
              cur_row_q <= (cur_row_q == 3'd4) ? 3'd0 : cur_row_q + 3'd1;
            end else if (btn_l) begin
              cur_col_q <= (cur_col_q == 3'd0) ? 3'd4 : cur_col_q - 3'd1;
            end else if (btn_r) begin
              cur_col_q <= (cur_col_q == 3'd4) ? 3'd0 : cur_col_q + 3'd1;
            end
`ifdef MOVE_TIMEOUT_EN
            if (place && cur_empty) begin
              idle_cnt_q <= 32'd0;
            end else if (idle_cnt_q == TimeoutLast) begin
              idle_cnt_q <= 32'd0;
              cur_p2_q   <= ~cur_p2_q;
            end else begin
              idle_cnt_q <= idle_cnt_q + 32'd1;
            end
`endif
          end

          StCheck: begin
            run_q <= run_next;
            if (hit) win_q <= 1'b1;
            if (off_q == OffLast) begin
              off_q <= 4'd0;
              if (axis_q == 2'd3) begin
                // Outcome is registered here so it is valid during RESOLVE.
                state_q <= StResolve;
                if (win_q || hit) begin
                  game_finished_q <= 1'b1;
                  last_winner_q   <= cur_p2_q;
                  draw_q          <= 1'b0;
                end else if (move_cnt_q == 5'd25) begin
                  game_finished_q <= 1'b1;
                  draw_q          <= 1'b1;
                end
              end else begin
                axis_q <= axis_q + 2'd1;
              end
            end else begin
              off_q <= off_q + 4'd1;
            end
          end

          StResolve: begin
            if (win_q || (move_cnt_q == 5'd25)) begin
              state_q <= StDone;
            end else begin
              cur_p2_q <= ~cur_p2_q;
              state_q  <= StIdle;
`ifdef MOVE_TIMEOUT_EN
              idle_cnt_q <= 32'd0;
`endif
            end
          end

          StDone: begin
            state_q <= StDone;
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rd_cell       = rd_cell_q;
  assign cursor_row    = cur_row_q;
  assign cursor_col    = cur_col_q;
  assign player1_turn  = (state_q != StDone) && !cur_p2_q;
  assign player2_turn  = (state_q != StDone) && cur_p2_q;
  assign game_finished = game_finished_q;
  assign last_winner   = last_winner_q;
  assign draw          = draw_q;
  assign invalid_move  = invalid_move_q;
  assign busy          = (state_q == StCheck);

endmodule
